// File: rtl/mac_mode_counter.sv
// Parametrised MAC step counter: up/down against a programmable limit, with
// clear, clamped load, wrap or saturate behaviour, and registered event pulses.
module mac_mode_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_enb,
  input  logic             count_reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = 1'b0;
    if (count_reset) begin
      count_d = '0;
    end else if (load_en) begin
      count_d = (load_value <= limit) ? load_value : limit;
    end else if (count_enb) begin
      if (up_down) begin
        // At or above limit never increments, so limit=all-ones cannot overflow
        if (count_q < limit) begin
          count_d = count_q + ONE;
        end else if (!sat_mode) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = limit;
          sat_d   = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - ONE;
        end else if (!sat_mode) begin
          count_d = limit;
          wrap_d  = 1'b1;
        end else begin
          sat_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count_out  = count_q;
  assign wrap_pulse = wrap_q;
  assign sat_hit    = sat_q;
  assign tc         = up_down ? (count_q >= limit) : (count_q == '0);

endmodule

// File: tb/tb_mac_mode_counter.sv
// Scoreboard bench for mac_mode_counter: WIDTH=4 and WIDTH=8 instances share
// stimulus (the 4-bit one sees the low nibble) and are checked against a model.
module tb_mac_mode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cr = 1'b0, ld = 1'b0, en = 1'b0, ud = 1'b1, sm = 1'b0;
  logic [7:0] lv = '0, lim = '0;

  logic [3:0] c4;
  logic       tc4, wp4, sh4;
  logic [7:0] c8;
  logic       tc8, wp8, sh8;

  mac_mode_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .count_enb(en), .count_reset(cr), .load_en(ld),
    .load_value(lv[3:0]), .limit(lim[3:0]), .up_down(ud), .sat_mode(sm),
    .count_out(c4), .tc(tc4), .wrap_pulse(wp4), .sat_hit(sh4)
  );

  mac_mode_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .count_enb(en), .count_reset(cr), .load_en(ld),
    .load_value(lv), .limit(lim), .up_down(ud), .sat_mode(sm),
    .count_out(c8), .tc(tc8), .wrap_pulse(wp8), .sat_hit(sh8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c4; bit w4; bit s4; bit t4;
    int c8; bit w8; bit s8; bit t8;
  } exp_t;

  exp_t q[$];
  int   m4 = 0, m8 = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Reference rules for one clock edge on a w-bit counter
  function automatic int nxt(input int w, input int cnt, input bit c_r, input bit l_d,
                             input bit e_n, input bit u_d, input bit s_m,
                             input int lvi, input int limi, output bit wr, output bit sh);
    int top = (1 << w) - 1;
    int l   = lvi & top;
    int lm  = limi & top;
    wr = 1'b0;
    sh = 1'b0;
    if (c_r) return 0;
    if (l_d) return (l > lm) ? lm : l;
    if (!e_n) return cnt;
    if (u_d) begin
      if (cnt < lm) return (cnt + 1) % (top + 1);
      if (s_m) begin sh = 1'b1; return lm; end
      wr = 1'b1;
      return 0;
    end
    if (cnt > 0) return cnt - 1;
    if (s_m) begin sh = 1'b1; return 0; end
    wr = 1'b1;
    return lm;
  endfunction

  function automatic bit tcm(input int w, input int cnt, input bit u_d, input int limi);
    int lm = limi & ((1 << w) - 1);
    return u_d ? (cnt >= lm) : (cnt == 0);
  endfunction

  task automatic step(input bit c_r, input bit l_d, input bit e_n, input bit u_d,
                      input bit s_m, input int lvi, input int limi);
    exp_t e;
    @(negedge clk);
    cr = c_r; ld = l_d; en = e_n; ud = u_d; sm = s_m;
    lv = 8'(lvi); lim = 8'(limi);
    m4 = nxt(4, m4, c_r, l_d, e_n, u_d, s_m, lvi, limi, e.w4, e.s4);
    m8 = nxt(8, m8, c_r, l_d, e_n, u_d, s_m, lvi, limi, e.w8, e.s8);
    e.c4 = m4; e.t4 = tcm(4, m4, u_d, limi);
    e.c8 = m8; e.t8 = tcm(8, m8, u_d, limi);
    q.push_back(e);
  endtask

  task automatic check_reset_state();
    chk("rst_count4", 32'(c4), 0);
    chk("rst_wrap4",  32'(wp4), 0);
    chk("rst_sat4",   32'(sh4), 0);
    chk("rst_tc4",    32'(tc4), 32'(tcm(4, 0, ud, int'(lim))));
    chk("rst_count8", 32'(c8), 0);
    chk("rst_wrap8",  32'(wp8), 0);
    chk("rst_sat8",   32'(sh8), 0);
  endtask

  // Assert reset between edges, check it took effect without a clock, release later
  task automatic async_reset();
    @(posedge clk);
    #3;
    cr = 1'b0; ld = 1'b0; en = 1'b0;
    rst = 1'b0;
    #1;
    m4 = 0; m8 = 0;
    check_reset_state();
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count4", 32'(c4),  32'(e.c4));
        chk("wrap4",  32'(wp4), 32'(e.w4));
        chk("sat4",   32'(sh4), 32'(e.s4));
        chk("tc4",    32'(tc4), 32'(e.t4));
        chk("count8", 32'(c8),  32'(e.c8));
        chk("wrap8",  32'(wp8), 32'(e.w8));
        chk("sat8",   32'(sh8), 32'(e.s8));
        chk("tc8",    32'(tc8), 32'(e.t8));
      end
    end
  end

  initial begin : stimulus
    int rlim;
    bit rud, rsm;
    #1 rst = 1'b0;
    #1 check_reset_state();
    @(negedge clk);
    #2 rst = 1'b1;

    // Reset while holding 9, then idle after release
    step(0, 1, 0, 1, 0, 9, 15);
    step(0, 0, 0, 1, 0, 0, 15);
    async_reset();
    step(0, 0, 0, 1, 0, 0, 15);
    step(0, 0, 0, 1, 0, 0, 15);

    // Up wrap at limit 5
    step(1, 0, 0, 1, 0, 0, 5);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0, 0, 5);

    // Down saturate from 2 with limit 9
    step(0, 1, 0, 0, 1, 2, 9);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0, 9);

    // Priority
    step(0, 1, 0, 1, 0, 3, 9);
    step(1, 1, 1, 1, 0, 7, 9);
    step(0, 1, 1, 1, 0, 7, 9);

    // Clamp and limit changes
    step(0, 1, 0, 1, 0, 12, 6);
    step(0, 0, 1, 1, 0, 0, 4);
    step(0, 1, 0, 1, 0, 3, 6);
    step(0, 0, 1, 0, 0, 0, 2);

    // Full range
    step(1, 0, 0, 1, 0, 0, 255);
    for (int i = 0; i < 256; i++) step(0, 0, 1, 1, 0, 0, 255);

    // limit = 0 in all four mode combinations
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) step(0, 0, 1, k[1], k[0], 0, 0);

    // Randomised traffic with a mid-run reset
    rlim = 10; rud = 1'b1; rsm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       rlim = 0;
          1:       rlim = 255;
          default: rlim = int'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 7) == 0) rud = ~rud;
      if ($urandom_range(0, 15) == 0) rsm = ~rsm;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) < 8, rud, rsm, int'($urandom_range(0, 255)), rlim);
      if (i == 200) async_reset();
    end

    step(0, 0, 0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
